bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter for the 7-segment display path, using iterative shift-and-add-3 (double dabble). It uses one bank of four digit-adjust cells, reused over WIDTH clock cycles, in place of a full combinational add-3 tree. A START/BUSY/DONE handshake sequences each conversion. Results are held in output registers for the display decoders until the next conversion completes.

---
 rtl/bin2bcd_seq_pkg.sv | 16 +
 rtl/bin2bcd_seq_digit_adj.sv | 16 +
 rtl/bin2bcd_seq.sv | 97 +++++++++
 tb/tb_bin2bcd_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// State encoding is fixed so debug/state observers can decode it directly.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit adjust cell: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_d,
  output logic [DIGIT_W-1:0] o_d
);

  // Legal inputs never exceed 9, so the sum (max 12) needs no carry out.
  always_comb begin
    if (i_d >= DIGIT_W'(ADJ_THRESH)) o_d = i_d + DIGIT_W'(ADJ_ADD);
    else                             o_d = i_d;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter: one bank of adjust cells reused over
// WIDTH shift cycles, sequenced by a START/BUSY/DONE handshake.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             START,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       BCD_0,
  output logic [3:0]       BCD_1,
  output logic [3:0]       BCD_2,
  output logic [3:0]       BCD_3,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SCR_W = NUM_DIGITS * DIGIT_W;

  // Handshake: START is sampled only in IDLE; while BUSY is high further
  // START pulses are ignored (not queued); DONE is a one-cycle pulse during
  // which BCD_0..3 hold the fresh result, and they hold it until the next DONE.
  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_bin;
  logic [SCR_W-1:0]   r_scratch;
  logic [SCR_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCR_W-1:0]   w_adj;
  logic [SCR_W-1:0]   w_shift_scr;
  logic               w_cnt_last;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_d (r_scratch[g*DIGIT_W +: DIGIT_W]),
      .o_d (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The bit leaving scratch MSB is dropped; it is always 0 for WIDTH <= 13.
  assign w_shift_scr = SCR_W'({w_adj, r_bin[WIDTH-1]});
  assign w_cnt_last  = (r_cnt == CNT_W'(1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (START) w_next = ST_CONV;
      ST_CONV: if (w_cnt_last) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_bin     <= B;
            r_scratch <= '0;
            r_cnt     <= CNT_W'(WIDTH);
          end
        end
        ST_CONV: begin
          r_scratch <= w_shift_scr;
          r_bin     <= r_bin << 1;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (w_cnt_last) r_bcd <= w_shift_scr;
        end
        default: ;
      endcase
    end
  end

  assign BUSY        = (r_state == ST_CONV) || (r_state == ST_FIN);
  assign DONE        = (r_state == ST_FIN);
  assign BCD_0       = r_bcd[3:0];
  assign BCD_1       = r_bcd[7:4];
  assign BCD_2       = r_bcd[11:8];
  assign BCD_3       = r_bcd[15:12];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, handshake corner cases,
// asynchronous abort and a full 10-bit sweep against a decimal model.
module tb_bin2bcd_seq;

  localparam int W = 10;

  typedef struct {
    int          b;
    logic [15:0] exp;
  } vec_t;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] B = '0;
  logic         BUSY, DONE;
  logic [3:0]   BCD_0, BCD_1, BCD_2, BCD_3;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  logic prev_done = 1'b0;
  logic [15:0] exp_q[$];

  bin2bcd_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .B(B),
    .BUSY(BUSY), .DONE(DONE),
    .BCD_0(BCD_0), .BCD_1(BCD_1), .BCD_2(BCD_2), .BCD_3(BCD_3),
    .o_dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every DONE pops one expected result.
  always @(negedge CLK) begin
    if (nRST) begin
      if (DONE) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_width", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("bcd_result", {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, {16'd0, e});
        end
        check("digits_le9", {31'd0, (BCD_0 > 4'd9) || (BCD_1 > 4'd9) ||
                             (BCD_2 > 4'd9) || (BCD_3 > 4'd9)}, 32'd0);
      end
      prev_done = DONE;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Starts a conversion from IDLE and waits (bounded) for DONE.
  task automatic run_conv(input int b, output int lat, output int busy_n);
    bit seen;
    @(negedge CLK);
    START = 1'b1;
    B = W'(b);
    @(posedge CLK);
    exp_q.push_back(ref_bcd(b));
    #1 START = 1'b0;
    lat = 0;
    busy_n = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      lat++;
      if (BUSY) busy_n++;
      if (DONE) seen = 1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  initial begin
    vec_t vecs[9];
    int lat, busy_n, dc0, t1;

    vecs[0] = '{0,    16'h0000};
    vecs[1] = '{1023, 16'h1023};
    vecs[2] = '{999,  16'h0999};
    vecs[3] = '{512,  16'h0512};
    vecs[4] = '{1,    16'h0001};
    vecs[5] = '{9,    16'h0009};
    vecs[6] = '{10,   16'h0010};
    vecs[7] = '{99,   16'h0099};
    vecs[8] = '{100,  16'h0100};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_bcd", {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Table vectors: also latency, busy length and DONE de-assertion
    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].b, lat, busy_n);
      check("latency", lat, W + 1);
      check("busy_len", busy_n, W + 1);
      check("done_low_after", {31'd0, DONE}, 32'd0);
      check("busy_low_after", {31'd0, BUSY}, 32'd0);
      check("table_hold", {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, {16'd0, vecs[i].exp});
    end

    // START pulses during CONV and FIN are ignored
    dc0 = done_cnt;
    @(negedge CLK);
    START = 1'b1; B = W'(7);
    @(posedge CLK);
    exp_q.push_back(16'h0007);
    #1 START = 1'b0;
    repeat (3) @(negedge CLK);
    START = 1'b1; B = W'(300);
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 40 && !DONE; i++) @(negedge CLK);
    START = 1'b1; B = W'(300);
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (20) @(negedge CLK);
    check("ignore_one_done", done_cnt - dc0, 1);
    check("ignore_result", {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, 32'h0007);
    check("ignore_idle", {31'd0, BUSY}, 32'd0);

    // START held high: back-to-back conversions, 12 cycles apart
    dc0 = done_cnt;
    @(negedge CLK);
    START = 1'b1; B = W'(512);
    @(posedge CLK);
    exp_q.push_back(16'h0512);
    exp_q.push_back(16'h0007);
    #1 B = W'(7);
    for (int i = 0; i < 40 && !DONE; i++) @(negedge CLK);
    check("held_first_done", {31'd0, DONE}, 32'd1);
    t1 = cyc;
    for (int i = 1; i <= 11; i++) begin
      @(negedge CLK);
      if (i == 2) START = 1'b0;
      check("held_hold", {15'd0, DONE, BCD_3, BCD_2, BCD_1, BCD_0}, 32'h0512);
    end
    @(negedge CLK);
    check("held_second_done", {31'd0, DONE}, 32'd1);
    check("held_spacing", cyc - t1, W + 2);
    repeat (3) @(negedge CLK);
    check("held_two_dones", done_cnt - dc0, 2);

    // Asynchronous reset aborts a conversion in progress
    run_conv(1023, lat, busy_n);
    dc0 = done_cnt;
    @(negedge CLK);
    START = 1'b1; B = W'(5);
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (3) @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_done", {31'd0, DONE}, 32'd0);
    check("abort_bcd", {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (15) @(negedge CLK);
    check("abort_no_done", done_cnt - dc0, 0);
    check("abort_bcd_idle", {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, 32'd0);
    run_conv(5, lat, busy_n);
    check("post_abort_latency", lat, W + 1);

    // Full sweep against the decimal model
    for (int v = 0; v < (1 << W); v++) begin
      run_conv(v, lat, busy_n);
    end

    repeat (3) @(negedge CLK);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
